// File: rtl/qdiv_ctrl.sv
// Front end for a serial signed-magnitude divider: FIFO-buffered operands, one divide in flight, divide-by-zero and timeout results.
// Result latency is divider latency + 3 edges; in_ready drops when the FIFO is full, and the FSM stalls while the output register is held.
module qdiv_ctrl #(
  parameter int N       = 32,
  parameter int Q       = 15,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 in_dividend,
  input  logic [N-1:0]                 in_divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0]                 out_quotient,
  output logic                         out_dz,
  output logic                         out_timeout,
  output logic                         div_start,
  output logic [N-1:0]                 div_dividend,
  output logic [N-1:0]                 div_divisor,
  input  logic [N-1:0]                 div_quotient,
  input  logic                         div_complete,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT-1);

  if (Q < 0 || Q > N-2 || DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0 || TIMEOUT < 4) begin : g_bad_params
    $error("qdiv_ctrl: illegal parameter combination");
  end

  typedef struct packed {
    logic [N-1:0] dvd;
    logic [N-1:0] dvs;
  } pair_t;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY} state_t;

  pair_t           r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic            r_out_valid, r_out_dz, r_out_to;
  logic [N-1:0]    r_out_q;
  logic            r_div_start;
  logic [N-1:0]    r_div_dvd, r_div_dvs;

  pair_t           w_head;
  logic            w_push, w_pop, w_nonempty, w_out_free, w_timed_out;
  logic            w_load, w_load_dz, w_load_to, w_launch, w_timer_clr, w_abort;
  logic [N-1:0]    w_load_q;

  assign in_ready    = (r_count != FULL_CNT);
  assign w_push      = in_valid & in_ready;
  assign w_nonempty  = (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_out_free  = !r_out_valid || out_ready;
  assign w_timed_out = (r_timer == T_LAST);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{dvd: in_dividend, dvs: in_divisor};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Any div_complete value other than a clean 1 falls through the == 1'b1 tests and reads as busy.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_load_q    = '0;
    w_load_dz   = 1'b0;
    w_load_to   = 1'b0;
    w_launch    = 1'b0;
    w_timer_clr = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nonempty && w_out_free) begin
          if (w_head.dvs[N-2:0] == '0) begin
            w_load    = 1'b1;
            w_load_q  = {w_head.dvd[N-1] ^ w_head.dvs[N-1], {(N-1){1'b1}}};
            w_load_dz = 1'b1;
            w_pop     = 1'b1;
          end else if (div_complete == 1'b1) begin
            w_launch    = 1'b1;
            w_timer_clr = 1'b1;
            w_state_nxt = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        if (div_complete == 1'b1) begin
          w_abort = w_timed_out && w_out_free;
        end else begin
          w_timer_clr = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_out_free) begin
          if (div_complete == 1'b1) begin
            w_load      = 1'b1;
            w_load_q    = div_quotient;
            w_pop       = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_abort = w_timed_out;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_load      = 1'b1;
      w_load_q    = '0;
      w_load_to   = 1'b1;
      w_pop       = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_timer_clr) begin
        r_timer <= '0;
      end else if (r_state != S_IDLE && !w_timed_out) begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_q     <= '0;
      r_out_dz    <= 1'b0;
      r_out_to    <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_q     <= w_load_q;
      r_out_dz    <= w_load_dz;
      r_out_to    <= w_load_to;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_q     <= '0;
      r_out_dz    <= 1'b0;
      r_out_to    <= 1'b0;
    end
  end

  // Operands stay on div_dividend/div_divisor after the pulse until the next launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_start <= 1'b0;
      r_div_dvd   <= '0;
      r_div_dvs   <= '0;
    end else begin
      r_div_start <= w_launch;
      if (w_launch) begin
        r_div_dvd <= w_head.dvd;
        r_div_dvs <= w_head.dvs;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_quotient = r_out_q;
  assign out_dz       = r_out_dz;
  assign out_timeout  = r_out_to;
  assign div_start    = r_div_start;
  assign div_dividend = r_div_dvd;
  assign div_divisor  = r_div_dvs;
  assign busy         = (r_state != S_IDLE);
  assign fifo_count   = r_count;

endmodule

// File: tb/tb_qdiv_ctrl.sv
// Bench for qdiv_ctrl: behavioural serial divider, scoreboard queue of expected results, negedge monitor.
module tb_qdiv_ctrl;
  localparam int N       = 32;
  localparam int Q       = 15;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 46;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       in_valid, in_ready;
  logic [N-1:0]               in_dividend, in_divisor;
  logic                       out_valid, out_ready;
  logic [N-1:0]               out_quotient;
  logic                       out_dz, out_timeout;
  logic                       div_start;
  logic [N-1:0]               div_dividend, div_divisor;
  logic [N-1:0]               div_quotient = '0;
  logic                       div_complete = 1'b1;
  logic                       busy;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  always #5 clk = ~clk;

  qdiv_ctrl #(.N(N), .Q(Q), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dividend(in_dividend), .in_divisor(in_divisor),
    .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
    .out_dz(out_dz), .out_timeout(out_timeout),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_complete(div_complete),
    .busy(busy), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [N-1:0] q;
    logic         dz;
    logic         to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   starts = 0;

  logic rr_mode = 1'b0;
  logic rr_bit = 1'b1;
  logic ready_force = 1'b1;
  assign out_ready = rr_mode ? rr_bit : ready_force;

  always begin
    @(posedge clk);
    #1 rr_bit = 1'($urandom_range(0, 1));
  end

  function automatic logic [N-1:0] qdiv_ref(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [63:0] num, den, res;
    num = {33'd0, a[30:0]} << Q;
    den = {33'd0, b[30:0]};
    res = (den == 64'd0) ? 64'd0 : num / den;
    return {a[31] ^ b[31], res[30:0]};
  endfunction

  function automatic exp_t make_exp(input logic [N-1:0] a, input logic [N-1:0] b, input bit hang);
    exp_t e;
    if (b[30:0] == 31'd0) begin
      e.q = {a[31] ^ b[31], 31'h7FFF_FFFF}; e.dz = 1'b1; e.to = 1'b0;
    end else if (hang) begin
      e.q = '0; e.dz = 1'b0; e.to = 1'b1;
    end else begin
      e.q = qdiv_ref(a, b); e.dz = 1'b0; e.to = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Divider: samples start on a rising edge, complete drops, rises LAT edges later; freezes while dm_hang.
  logic         dm_busy = 1'b0;
  logic         dm_hang = 1'b0;
  int           dm_cnt = 0;
  logic [N-1:0] dm_a = '0, dm_b = '0;

  always @(posedge clk) begin
    if (div_start) begin
      dm_busy      <= 1'b1;
      dm_cnt       <= 1;
      dm_a         <= div_dividend;
      dm_b         <= div_divisor;
      div_complete <= 1'b0;
    end else if (dm_busy && !dm_hang) begin
      if (dm_cnt >= LAT) begin
        div_complete <= 1'b1;
        div_quotient <= qdiv_ref(dm_a, dm_b);
        dm_busy      <= 1'b0;
      end else begin
        dm_cnt <= dm_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (div_start) begin
        starts++;
        chk("launch_needs_idle_divider", {31'd0, div_complete}, 32'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%h required=none", out_quotient);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result_quotient", out_quotient, mon_e.q);
          chk("result_dz", {31'd0, out_dz}, {31'd0, mon_e.dz});
          chk("result_timeout", {31'd0, out_timeout}, {31'd0, mon_e.to});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input bit hang);
    int w;
    w = 0;
    in_valid = 1'b1; in_dividend = a; in_divisor = b;
    while (!in_ready && w < 400) begin step(); w++; end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_stall actual=in_ready_low required=accept_within_400");
      in_valid = 1'b0;
    end else begin
      step();
      exp_q.push_back(make_exp(a, b, hang));
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < budget) begin step(); w++; end
    chk({"drain_", tag}, exp_q.size(), 32'd0);
  endtask

  function automatic logic [N-1:0] rand_pair_word(input bit allow_zero, input bit is_divisor);
    logic [30:0] mag;
    if (is_divisor) begin
      if (allow_zero && $urandom_range(0, 7) == 0) mag = 31'd0;
      else mag = 31'($urandom_range(32'h100, 32'h7FFF_FFFF));
    end else begin
      mag = 31'($urandom_range(0, 32'h00FF_FFFF));
    end
    return {1'($urandom_range(0, 1)), mag};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, s0, w;
    logic [N-1:0] t4a [6];
    logic [N-1:0] t4b [6];
    logic [N-1:0] a, b;
    in_valid = 1'b0; in_dividend = '0; in_divisor = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_quotient", out_quotient, 32'd0);
    chk("rst_flags", {30'd0, out_dz, out_timeout}, 32'd0);
    chk("rst_div_start", {31'd0, div_start}, 32'd0);
    chk("rst_div_operands", div_dividend | div_divisor, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    rst = 1'b0;
    step();

    // T1: 3.0 / 1.5 and its latency
    push(32'h0001_8000, 32'h0000_C000, 1'b0);
    in_valid = 1'b0;
    chk("t1_ref_model", qdiv_ref(32'h0001_8000, 32'h0000_C000), 32'h0001_0000);
    n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    chk("t1_latency", n, 32'd49);
    drain("t1", 100);

    // T2: sign handling
    push(32'h8001_8000, 32'h0000_C000, 1'b0);
    push(32'h0000_8000, 32'h8000_8000, 1'b0);
    in_valid = 1'b0;
    drain("t2", 300);

    // T3: divide by negative zero saturates without touching the divider
    s0 = starts;
    push(32'h0001_0000, 32'h8000_0000, 1'b0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("t3_dz_fast", {31'd0, n <= 3}, 32'd1);
    drain("t3", 20);
    chk("t3_no_start", starts, s0);

    // T4: output held, FIFO fills, sixth push stalls, order preserved after release
    ready_force = 1'b0;
    for (int i = 0; i < 6; i++) begin
      t4a[i] = rand_pair_word(1'b0, 1'b0);
      t4b[i] = rand_pair_word(1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) push(t4a[i], t4b[i], 1'b0);
    in_valid = 1'b1; in_dividend = t4a[5]; in_divisor = t4b[5];
    for (int i = 0; i < 20; i++) begin
      chk("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
      step();
    end
    chk("t4_fifo_full", {29'd0, fifo_count}, DEPTH);
    chk("t4_first_held", {31'd0, out_valid}, 32'd1);
    chk("t4_held_value", out_quotient, exp_q[0].q);
    ready_force = 1'b1;
    push(t4a[5], t4b[5], 1'b0);
    in_valid = 1'b0;
    drain("t4", 1000);

    // T5: hung divider aborts, then the next request goes through
    dm_hang = 1'b1;
    push(32'h0003_0000, 32'h0001_0000, 1'b1);
    in_valid = 1'b0;
    drain("t5_abort", TIMEOUT + 40);
    dm_hang = 1'b0;
    push(32'h0000_4000, 32'h0000_2000, 1'b0);
    in_valid = 1'b0;
    drain("t5_next", 300);

    // T6: reset mid-divide; the next launch must wait for the divider to finish
    push(32'h0005_0000, 32'h0000_8000, 1'b0);
    in_valid = 1'b0;
    w = 0;
    while (!busy && w < 20) begin step(); w++; end
    repeat (10) step();
    push(32'h0002_0000, 32'h0001_0000, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    s0 = starts;
    push(32'h8000_6000, 32'h0000_3000, 1'b0);
    in_valid = 1'b0;
    repeat (5) step();
    chk("t6_wait_for_divider", starts, s0);
    drain("t6", 300);

    // Random traffic with random back-pressure
    rr_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = rand_pair_word(1'b0, 1'b0);
      b = rand_pair_word(1'b1, 1'b1);
      push(a, b, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
    rr_mode = 1'b0;
    ready_force = 1'b1;
    drain("random", 4000);
    repeat (3) step();
    chk("end_fifo_empty", {29'd0, fifo_count}, 32'd0);
    chk("end_out_idle", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
